// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: SSD1306 opcodes, addressing-mode encodings, parser states and opcode classification.
package ssd1306_pkg;
  localparam logic [7:0] SET_CONTRAST  = 8'h81;
  localparam logic [7:0] DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] DISPLAY_ON    = 8'hAF;
  localparam logic [7:0] INVERT_OFF    = 8'hA6;
  localparam logic [7:0] INVERT_ON     = 8'hA7;
  localparam logic [7:0] CHARGEPUMP    = 8'h8D;
  localparam logic [7:0] MEMORYMODE    = 8'h20;
  localparam logic [7:0] COLUMNADDR    = 8'h21;
  localparam logic [7:0] PAGEADDR      = 8'h22;
  localparam logic [7:0] SETMULTIPLEX  = 8'hA8;
  localparam logic [7:0] SETDISPOFFSET = 8'hD3;
  localparam logic [7:0] SETCLOCKDIV   = 8'hD5;
  localparam logic [7:0] SETPRECHARGE  = 8'hD9;
  localparam logic [7:0] SETCOMPINS    = 8'hDA;
  localparam logic [7:0] SETVCOMDETECT = 8'hDB;
  typedef enum logic [1:0] {MM_HORIZ = 2'b00, MM_VERT = 2'b01, MM_PAGE = 2'b10} mem_mode_t;
  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      SET_CONTRAST, CHARGEPUMP, MEMORYMODE, SETMULTIPLEX, SETDISPOFFSET,
      SETCLOCKDIV, SETPRECHARGE, SETCOMPINS, SETVCOMDETECT: return 2'd1;
      COLUMNADDR, PAGEADDR: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
  // Single-byte opcodes that are legal but change nothing we model.
  function automatic logic is_nop(input logic [7:0] op);
    return (op[7:6] == 2'b01) || (op inside {8'hA0, 8'hA1, 8'hA4, 8'hA5, 8'hC0, 8'hC8});
  endfunction
endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// ssd1306_spi_rx_if: OLED 4-wire SPI pins plus the framebuffer write port of the receiver.
interface ssd1306_spi_rx_if #(parameter int AW = 10);
  logic          oled_sclk;
  logic          oled_sdin;
  logic          oled_dc;
  logic          oled_res;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
  modport master (output oled_sclk, oled_sdin, oled_dc, oled_res, input fb_we, fb_addr, fb_wdata);
  modport slave  (input oled_sclk, oled_sdin, oled_dc, oled_res, output fb_we, fb_addr, fb_wdata);
endinterface

// File: rtl/ssd1306_spi_deser.sv
// ssd1306_spi_deser: pin synchronisers, sclk rising-edge detect and MSB-first byte assembly.
module ssd1306_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oled_sclk,
  input  logic       oled_sdin,
  input  logic       oled_dc,
  input  logic       oled_res,
  output logic       srst,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       rx_dc
);
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] s;
  logic       sclk_prev_q, sclk_prev_d, stb_q, stb_d, dc_q, dc_d, rise;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  // s = {res, dc, sdin, sclk} after the synchroniser chain
  assign s    = sync_q[SYNC_STAGES-1];
  assign srst = !rst_n || !s[3];
  assign rise = s[0] && !sclk_prev_q;
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {oled_res, oled_dc, oled_sdin, oled_sclk}};
    sclk_prev_d = s[0];
    shift_d     = rise ? {shift_q[5:0], s[1]} : shift_q;
    cnt_d       = rise ? cnt_q + 3'd1 : cnt_q;
    stb_d       = rise && (cnt_q == 3'd7);
    byte_d      = stb_d ? {shift_q, s[1]} : byte_q;
    dc_d        = stb_d ? s[2] : dc_q;
  end
  always_ff @(posedge clk) begin
    sync_q      <= sync_d;
    sclk_prev_q <= sclk_prev_d;
    shift_q     <= shift_d;
    byte_q      <= byte_d;
    dc_q        <= dc_d;
    if (srst) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end
  assign byte_stb = stb_q;
  assign rx_byte  = byte_q;
  assign rx_dc    = dc_q;
endmodule

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx: SSD1306 receive model; splits SPI bytes into command decode and framebuffer writes.
// Define SSD1306_RX_BYTE_MON_EN to add the mon_valid/mon_byte/mon_dc raw byte monitor.
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = $clog2(COLS * PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd1306_spi_rx_if.slave   bus,
  output logic              display_on,
  output logic              invert,
  output logic [7:0]        contrast,
  output logic              charge_pump_en,
  output logic [1:0]        mem_mode,
  output logic              cmd_err
`ifdef SSD1306_RX_BYTE_MON_EN
  ,
  output logic              mon_valid,
  output logic [7:0]        mon_byte,
  output logic              mon_dc
`endif
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  logic          srst, stb, dc;
  logic [7:0]    b;
  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d, arg1_q, arg1_d, contrast_q, contrast_d, fb_wdata_q, fb_wdata_d, col8;
  logic          display_on_q, display_on_d, invert_q, invert_d, cp_q, cp_d;
  logic          fb_we_q, fb_we_d, err_q, err_d, page_mode;
  logic [1:0]    mem_mode_q, mem_mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d, col_inc;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d, page_inc;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  ssd1306_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .oled_sclk(bus.oled_sclk),
    .oled_sdin(bus.oled_sdin),
    .oled_dc  (bus.oled_dc),
    .oled_res (bus.oled_res),
    .srst     (srst),
    .byte_stb (stb),
    .rx_byte  (b),
    .rx_dc    (dc)
  );
  function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
    return (32'(v) >= COLS) ? CW'(COLS - 1) : CW'(v);
  endfunction
  assign col8      = 8'(col_q);
  assign col_inc   = (32'(col_q) == COLS - 1) ? '0 : col_q + 1'b1;
  assign page_inc  = (32'(page_q) == PAGES - 1) ? '0 : page_q + 1'b1;
  assign page_mode = mem_mode_q == MM_PAGE;
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg1_d       = arg1_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    contrast_d   = contrast_q;
    cp_d         = cp_q;
    mem_mode_d   = mem_mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    fb_we_d      = 1'b0;
    err_d        = 1'b0;
    if (stb && dc) begin
      // a data byte abandons any half-received command
      err_d      = state_q != IDLE;
      state_d    = IDLE;
      fb_we_d    = 1'b1;
      fb_addr_d  = AW'(page_q) * AW'(COLS) + AW'(col_q);
      fb_wdata_d = b;
      case (mem_mode_q)
        MM_HORIZ:
          if (col_q == col_end_q) begin
            col_d  = col_start_q;
            page_d = (page_q == page_end_q) ? page_start_q : page_inc;
          end else col_d = col_inc;
        MM_VERT:
          if (page_q == page_end_q) begin
            page_d = page_start_q;
            col_d  = (col_q == col_end_q) ? col_start_q : col_inc;
          end else page_d = page_inc;
        default: col_d = col_inc;
      endcase
    end else if (stb) begin
      case (state_q)
        IDLE:
          if (arg_count(b) != 2'd0) begin
            op_d    = b;
            state_d = ARG1;
          end else begin
            display_on_d = (b == DISPLAY_ON) || (display_on_q && b != DISPLAY_OFF);
            invert_d     = (b == INVERT_ON) || (invert_q && b != INVERT_OFF);
            if (page_mode && b[7:3] == 5'b10110) page_d = PW'(b[2:0]);
            if (page_mode && b[7:4] == 4'h0) col_d = clamp_col({col8[7:4], b[3:0]});
            if (page_mode && b[7:4] == 4'h1) col_d = clamp_col({b[3:0], col8[3:0]});
            err_d = !(is_nop(b) || b[7:5] == 3'b000 || b[7:3] == 5'b10110 ||
                      (b inside {DISPLAY_ON, DISPLAY_OFF, INVERT_ON, INVERT_OFF}));
          end
        ARG1:
          if (arg_count(op_q) == 2'd2) begin
            arg1_d  = b;
            state_d = ARG2;
          end else begin
            state_d    = IDLE;
            contrast_d = (op_q == SET_CONTRAST) ? b : contrast_q;
            cp_d       = (op_q == CHARGEPUMP) ? b[2] : cp_q;
            mem_mode_d = (op_q == MEMORYMODE && b[1:0] != 2'b11) ? b[1:0] : mem_mode_q;
          end
        ARG2: begin
          state_d = IDLE;
          if (op_q == COLUMNADDR) begin
            col_start_d = clamp_col(arg1_q);
            col_end_d   = clamp_col(b);
            col_d       = clamp_col(arg1_q);
          end else begin
            page_start_d = PW'(arg1_q[2:0]);
            page_end_d   = PW'(b[2:0]);
            page_d       = PW'(arg1_q[2:0]);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      arg1_q       <= '0;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      contrast_q   <= 8'h7F;
      cp_q         <= 1'b0;
      mem_mode_q   <= MM_PAGE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      fb_we_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg1_q       <= arg1_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      contrast_q   <= contrast_d;
      cp_q         <= cp_d;
      mem_mode_q   <= mem_mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_we_q      <= fb_we_d;
      err_q        <= err_d;
    end
  end
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign display_on     = display_on_q;
  assign invert         = invert_q;
  assign contrast       = contrast_q;
  assign charge_pump_en = cp_q;
  assign mem_mode       = mem_mode_q;
  assign cmd_err        = err_q;
`ifdef SSD1306_RX_BYTE_MON_EN
  logic       mon_valid_q, mon_valid_d, mon_dc_q, mon_dc_d;
  logic [7:0] mon_byte_q, mon_byte_d;
  always_comb begin
    mon_valid_d = stb;
    mon_byte_d  = stb ? b : mon_byte_q;
    mon_dc_d    = stb ? dc : mon_dc_q;
  end
  always_ff @(posedge clk) begin
    mon_byte_q <= mon_byte_d;
    mon_dc_q   <= mon_dc_d;
    if (srst) mon_valid_q <= 1'b0;
    else      mon_valid_q <= mon_valid_d;
  end
  assign mon_valid = mon_valid_q;
  assign mon_byte  = mon_byte_q;
  assign mon_dc    = mon_dc_q;
`endif
endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// tb_ssd1306_spi_rx: random SPI byte stream against a command-list reference model, scoreboarded.
module tb_ssd1306_spi_rx;
  localparam int COLS = 128, PAGES = 8, SS = 2, AW = 10, LAT = SS + 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ssd1306_spi_rx_if #(.AW(AW)) bus ();
  logic       display_on, invert, charge_pump_en, cmd_err;
  logic [7:0] contrast;
  logic [1:0] mem_mode;
`ifdef SSD1306_RX_BYTE_MON_EN
  logic       mon_valid, mon_dc;
  logic [7:0] mon_byte;
  logic [8:0] monq[$];
`endif
  ssd1306_spi_rx #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .display_on(display_on), .invert(invert),
    .contrast(contrast), .charge_pump_en(charge_pump_en), .mem_mode(mem_mode), .cmd_err(cmd_err)
`ifdef SSD1306_RX_BYTE_MON_EN
    , .mon_valid(mon_valid), .mon_byte(mon_byte), .mon_dc(mon_dc)
`endif
  );
  typedef struct {bit err; bit we; int addr; int data; int cyc;} ev_t;
  ev_t        expq[$];
  int         wr_log[$];
  int         checks = 0, fails = 0, cyc = 0, last_addr = -1, last_data = -1;
  int         m_disp, m_inv, m_con, m_cp, m_mm, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  logic [7:0] cq[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    m_disp = 0; m_inv = 0; m_con = 'h7F; m_cp = 0; m_mm = 2;
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    cq.delete();
  endtask
  function automatic int argc(input int op);
    if (op inside {'h81, 'h8D, 'h20, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) return 1;
    if (op inside {'h21, 'h22}) return 2;
    return 0;
  endfunction
  function automatic int clampc(input int v);
    return (v >= COLS) ? COLS - 1 : v;
  endfunction
  task automatic model_exec(output bit err);
    int op, a1, a2;
    bit pm;
    op  = int'(cq[0]);
    a1  = cq.size() > 1 ? int'(cq[1]) : 0;
    a2  = cq.size() > 2 ? int'(cq[2]) : 0;
    pm  = m_mm == 2;
    err = 0;
    case (op)
      'hAF: m_disp = 1;
      'hAE: m_disp = 0;
      'hA7: m_inv = 1;
      'hA6: m_inv = 0;
      'h81: m_con = a1;
      'h8D: m_cp = (a1 >> 2) & 1;
      'h20: if ((a1 & 3) != 3) m_mm = a1 & 3;
      'h21: begin m_cs = clampc(a1); m_ce = clampc(a2); m_col = m_cs; end
      'h22: begin m_ps = (a1 & 7) % PAGES; m_pe = (a2 & 7) % PAGES; m_page = m_ps; end
      'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'hA0, 'hA1, 'hA4, 'hA5, 'hC0, 'hC8: ;
      default:
        if (op >= 'hB0 && op <= 'hB7) begin
          if (pm) m_page = (op & 7) % PAGES;
        end else if (op <= 'h0F) begin
          if (pm) m_col = clampc((m_col & 'hF0) | op);
        end else if (op <= 'h1F) begin
          if (pm) m_col = clampc((m_col & 'h0F) | ((op & 'hF) << 4));
        end else if (!(op >= 'h40 && op <= 'h7F)) err = 1;
    endcase
  endtask
  task automatic model_byte(input logic [7:0] b, input bit d, input int scyc);
    ev_t e;
    e = '{err: 0, we: 0, addr: 0, data: int'(b), cyc: scyc + LAT};
    if (d) begin
      e.err  = cq.size() > 0;
      cq.delete();
      e.we   = 1;
      e.addr = m_page * COLS + m_col;
      if (m_mm == 0) begin
        if (m_col == m_ce) begin
          m_col  = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
        end else m_col = (m_col + 1) % COLS;
      end else if (m_mm == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
        end else m_page = (m_page + 1) % PAGES;
      end else m_col = (m_col + 1) % COLS;
    end else begin
      cq.push_back(b);
      if (cq.size() == 1 + argc(int'(cq[0]))) begin
        model_exec(e.err);
        cq.delete();
      end
    end
    if (e.err || e.we) expq.push_back(e);
`ifdef SSD1306_RX_BYTE_MON_EN
    monq.push_back({d, b});
`endif
  endtask
  task automatic check_status();
    chk("display_on", display_on, m_disp);
    chk("invert", invert, m_inv);
    chk("contrast", contrast, m_con);
    chk("charge_pump_en", charge_pump_en, m_cp);
    chk("mem_mode", mem_mode, m_mm);
  endtask
  task automatic tx_bit(input bit v, input bit d);
    bus.oled_sclk = 1'b0;
    bus.oled_sdin = v;
    bus.oled_dc   = d;
    repeat ($urandom_range(2, 3)) @(negedge clk);
    bus.oled_sclk = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit d);
    for (int i = 7; i >= 0; i--) begin
      tx_bit(b[i], d);
      if (i == 0) model_byte(b, d, cyc);
      repeat ($urandom_range(2, 3)) @(negedge clk);
    end
    bus.oled_sclk = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_status();
  endtask
  initial begin : monitor
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.fb_we === 1'b1 || cmd_err === 1'b1) begin
        if (bus.fb_we === 1'b1) begin
          last_addr = int'(bus.fb_addr);
          last_data = int'(bus.fb_wdata);
          wr_log.push_back(last_addr);
        end
        if (expq.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = expq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("cmd_err", cmd_err, e.err);
          chk("fb_we", bus.fb_we, e.we);
          if (e.we) begin
            chk("fb_addr", bus.fb_addr, e.addr);
            chk("fb_wdata", bus.fb_wdata, e.data);
          end
        end
      end
`ifdef SSD1306_RX_BYTE_MON_EN
      if (mon_valid === 1'b1) begin
        if (monq.size() == 0) chk("unexpected_mon", 1, 0);
        else chk("mon_byte_dc", {mon_dc, mon_byte}, monq.pop_front());
      end
`endif
    end
  end
  initial begin : stim
    int         ea[5] = '{894, 895, 1022, 1023, 894};
    int         nops[12] = '{'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'hA0, 'hA1, 'hA4, 'hA5, 'hC0, 'hC8};
    logic [7:0] rb;
    bus.oled_sclk = 1'b0; bus.oled_sdin = 1'b0; bus.oled_dc = 1'b0; bus.oled_res = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_status();
    // 0xAF with exact latency on display_on
    rb = 8'hAF;
    for (int i = 7; i >= 1; i--) begin
      tx_bit(rb[i], 1'b0);
      repeat (2) @(negedge clk);
    end
    tx_bit(rb[0], 1'b0);
    model_byte(rb, 1'b0, cyc);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("display_on_before_latency", display_on, 0);
    @(posedge clk);
    #1 chk("display_on_at_latency", display_on, 1);
    @(negedge clk);
    bus.oled_sclk = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_status();
    send_byte(8'h81, 0); send_byte(8'h3C, 0);
    chk("contrast_set", contrast, 8'h3C);
    send_byte(8'h81, 0); send_byte(8'h55, 1);
    chk("contrast_kept_after_abort", contrast, 8'h3C);
    chk("abort_write_addr", last_addr, 0);
    chk("abort_write_data", last_data, 8'h55);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h06, 0); send_byte(8'h07, 0);
    wr_log.delete();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    chk("window_write_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("window_addr", wr_log[i], ea[i]);
    send_byte(8'h20, 0); send_byte(8'h02, 0);
    send_byte(8'hB3, 0); send_byte(8'h05, 0); send_byte(8'h12, 0); send_byte(8'hAA, 1);
    chk("page_mode_addr", last_addr, 421);
    // oled_res pulse after 4 bits of a byte
    rb = 8'($urandom);
    for (int i = 7; i >= 4; i--) begin
      tx_bit(rb[i], 1'b0);
      repeat (2) @(negedge clk);
    end
    bus.oled_sclk = 1'b0;
    bus.oled_res  = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    bus.oled_res = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    model_reset();
    check_status();
    send_byte(8'hA7, 0);
    chk("invert_after_res", invert, 1);
    send_byte(8'hFF, 0);
    for (int n = 0; n < 400; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 35) send_byte(8'($urandom), 1);
      else begin
        k = $urandom_range(0, 15);
        case (k)
          0: rb = 8'hAF;  1: rb = 8'hAE;  2: rb = 8'hA7;  3: rb = 8'hA6;
          4: rb = 8'h81;  5: rb = 8'h8D;  6: rb = 8'h20;  7: rb = 8'h21;
          8: rb = 8'h22;
          9: rb = 8'(nops[$urandom_range(0, 5)]);
          10: rb = 8'(8'hB0 + $urandom_range(0, 7));
          11: rb = 8'($urandom_range(0, 31));
          12: rb = 8'($urandom_range('h40, 'h7F));
          13: rb = 8'(nops[$urandom_range(6, 11)]);
          14: rb = 8'($urandom);
          default: rb = 8'($urandom_range(0, 7));
        endcase
        send_byte(rb, 0);
      end
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_status();
      end
    end
    repeat (10) @(negedge clk);
    chk("pending_events", expq.size(), 0);
`ifdef SSD1306_RX_BYTE_MON_EN
    chk("pending_mon", monq.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ssd1306_spi_rx.md
Name: ssd1306_spi_rx

Overview:
- Receive-side model of the SSD1306 controller, at the far end of the OLED 4-wire SPI link (oled_sclk/oled_sdin/oled_dc/oled_res).
- Deserialises SPI mode-0, MSB-first bytes and splits them by DC: commands go to a command decoder, data goes to a framebuffer write port.
- Used as a bench/loopback target for the OLED init ROM sequencer, and as an on-FPGA display emulator feeding a video scanout.
- Everything runs in the system clock domain; the SPI pins are oversampled.

Parameters:
- COLS, 128, columns (segments) per page.
- PAGES, 8, pages (8 rows each).
- SYNC_STAGES, 2, flops in each pin synchroniser (minimum 2).
- AW, $clog2(COLS*PAGES), framebuffer address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- oled_sclk  in  1  SPI clock; idle low, sampled on rising edge.
- oled_sdin  in  1  SPI data, MSB first.
- oled_dc  in  1  0 = command byte, 1 = data byte.
- oled_res  in  1  display reset, active-low, asynchronous pin; synchronised internally.
- fb_we  out  1  framebuffer write strobe, one clk wide.
- fb_addr  out  AW  page*COLS + col.
- fb_wdata  out  8  data byte (bit0 = top row of the page).
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- invert  out  1  set by 0xA7, cleared by 0xA6.
- contrast  out  8  set by 0x81 nn.
- charge_pump_en  out  1  set to bit2 of the 0x8D argument.
- mem_mode  out  2  set by 0x20 nn (arg[1:0]); 00 horizontal, 01 vertical, 10 page, 11 ignored.
- cmd_err  out  1  one-clk pulse on an unknown opcode or an aborted command.

Behaviour:
- Reset: applies when rst_n=0 at a clk edge, or when synchronised oled_res=0. Values: fb_we=0, cmd_err=0, display_on=0, invert=0, contrast=0x7F, charge_pump_en=0, mem_mode=2'b10, col=0, page=0, col_start=0, col_end=COLS-1, page_start=0, page_end=PAGES-1, bit counter=0, FSM=IDLE. Framebuffer contents are untouched. A partial byte in flight is discarded.
- Sampling:
  - sclk, sdin and dc each pass through SYNC_STAGES flops.
  - A rising edge is detected when the synchronised sclk is 1 and its previous value was 0; sdin is shifted in on that edge.
  - On the 8th edge the byte, plus dc sampled on the same edge, is strobed internally, and the bit counter wraps to 0.
  - Input requirement: sclk high and low each ≥2 clk.
- Latency: fb_we, register updates and cmd_err take effect SYNC_STAGES+2 clk after the 8th sclk rising edge at the pin.
- FSM:
  - IDLE: on a command byte:
    - 2-byte opcodes (0x81, 0x8D, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB): latch opcode -> ARG1.
    - 3-byte opcodes (0x21, 0x22): latch opcode -> ARG1.
    - Single-byte opcodes: execute immediately.
  - ARG1: next command byte is arg1. 2-byte opcode: execute -> IDLE. 3-byte opcode: -> ARG2.
  - ARG2: next command byte is arg2; execute -> IDLE.
- Executed effects:
  - 0x21: col_start=arg1, col_end=arg2, col=col_start.
  - 0x22: page_start=arg1[2:0], page_end=arg2[2:0], page=page_start.
  - 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: accepted, no output effect.
  - Page mode only: 0xB0-0xB7 set page; 0x00-0x0F set col[3:0]; 0x10-0x1F set col[7:4]. Outside page mode these three ranges are accepted and ignored.
  - Accepted single-byte no-ops: 0x40-0x7F, 0xA0/0xA1, 0xA4/0xA5, 0xC0/0xC8.
  - Any other opcode in IDLE: cmd_err pulse, no other effect.
- Data byte in ARG1/ARG2: the pending command is abandoned, cmd_err pulses, FSM -> IDLE, and the byte is processed as data in the same cycle.
- Data byte (write, then advance): fb_we=1, fb_addr=page*COLS+col, fb_wdata=byte. Then:
  - Horizontal: if col==col_end, col=col_start and page = (page==page_end) ? page_start : page+1; else col+1.
  - Vertical: if page==page_end, page=page_start and col = (col==col_end) ? col_start : col+1; else page+1.
  - Page: col = (col==COLS-1) ? 0 : col+1; page unchanged.
- Bounds: a col argument ≥COLS is clamped to COLS-1. A start greater than its end is legal: wrap happens on equality only; otherwise the counter increments (modulo COLS/PAGES) until it reaches the end.
- Simultaneous rst_n=0 and a byte strobe: reset wins, no fb_we.

Optional Feature:
- Macro: SSD1306_RX_BYTE_MON_EN.
- Defined: adds outputs mon_valid (1), mon_byte (8) and mon_dc (1), pulsed with every received byte at the strobe cycle, regardless of FSM state. This lets a scoreboard compare against the init ROM stream.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ssd1306_pkg holds:
  - opcode constants (SET_CONTRAST 8'h81, DISPLAY_OFF 8'hAE, DISPLAY_ON 8'hAF, CHARGEPUMP 8'h8D, MEMORYMODE 8'h20, COLUMNADDR 8'h21, PAGEADDR 8'h22, …);
  - mem_mode encodings;
  - FSM state enum {IDLE, ARG1, ARG2};
  - an arg-count function (opcode -> 0/1/2).
- Sub-module ssd1306_spi_deser: synchronisers, edge detect, shift register and bit counter. Outputs byte_stb, byte, dc.

Test Plan:
- Reset, then command 0xAF -> display_on=1 at SYNC_STAGES+2 clk after the 8th edge; cmd_err stays 0.
- Commands 0x81 0x3C -> contrast=0x3C. Command 0x81 followed by data 0x55 -> cmd_err pulse, contrast unchanged, fb_we with addr 0, data 0x55.
- Commands 0x20 0x00, 0x21 0x7E 0x7F, 0x22 0x06 0x07, then 5 data bytes -> addresses 894, 895, 1022, 1023, 894.
- Page mode: commands 0xB3, 0x05, 0x12, then data 0xAA -> fb_addr=3*128+0x25=421.
- oled_res pulsed low mid-byte (after 4 bits), then a full command 0xA7 -> invert=1, no misaligned byte, no spurious cmd_err.
- Command 0xFF -> single cmd_err pulse, all outputs unchanged; with SSD1306_RX_BYTE_MON_EN, mon_valid=1, mon_byte=0xFF, mon_dc=0.
